spi_peripheral: RTL and testbench
=================================

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits (2..32).
REQ-002 Parameter CPOL, default 0, idle level of sck.
REQ-003 Parameter CPHA, default 0, 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 Port clk, input, 1, the only clock; all state SHALL be in this domain.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port cs, input, 1, chip select, active low, asynchronous to clk.
REQ-007 Port sck, input, 1, SPI clock, asynchronous to clk.
REQ-008 Port mosi, input, 1, serial data in.
REQ-009 Port miso, output, 1, serial data out.
REQ-010 Port tx_data, input, WIDTH, next word to transmit.
REQ-011 Port tx_valid, input, 1, tx_data offered.
REQ-012 Port tx_ready, output, 1, transmit holding register empty.
REQ-013 Port rx_data, output, WIDTH, last complete received word.
REQ-014 Port rx_valid, output, 1, rx_data holds an unconsumed word.
REQ-015 Port rx_ready, input, 1, consumer accepts rx_data.
REQ-016 Port ovr_clr, input, 1, clears rx_overrun.
REQ-017 Port rx_overrun, output, 1, sticky receive-overrun flag.

Function
REQ-018 cs, sck and mosi SHALL each pass through a 2-flop synchroniser; edges SHALL be detected on the synchronised signals.
REQ-019 Leading edge = sck leaving CPOL level; trailing edge = return to CPOL level; sample edge = leading if CPHA=0, else trailing; shift edge = the other.
REQ-020 FSM states IDLE, SHIFT; IDLE->SHIFT on synchronised cs falling; SHIFT->IDLE on synchronised cs rising, taking priority over any coincident sck edge.
REQ-021 On every word load, shift register SHALL take the holding register if full (tx_ready=0, holding then empties), else all-zeros (underrun, no flag).
REQ-022 A word load SHALL occur on IDLE->SHIFT and after every WIDTH-th sample edge, enabling back-to-back words under one cs assertion.
REQ-023 Data SHALL be MSB-first; miso = shift-register MSB in SHIFT, 0 in IDLE.
REQ-024 CPHA=0: first bit on miso by the IDLE->SHIFT transition; shift edges advance miso. CPHA=1: the first leading edge of each word presents the MSB without shifting; later shift edges advance.
REQ-025 Each sample edge SHALL shift synchronised mosi into the receive register LSB and increment a bit counter modulo WIDTH.
REQ-026 On counter wrap: rx_data <= assembled word and rx_valid <= 1, both one clk after the sample-edge detection.
REQ-027 rx_valid SHALL clear on a cycle with rx_valid=1 and rx_ready=1 unless a new word completes in that same cycle, in which case rx_valid stays 1 with the new data.
REQ-028 tx_valid&&tx_ready SHALL fill the holding register; tx_ready drops the next cycle; a coincident load and write SHALL hand over tx_data directly and leave the holding register empty.
REQ-029 cs deassertion mid-word SHALL discard the partial word (no rx_valid), clear the bit counter and keep the holding register contents.
REQ-030 sck high and low times SHALL each be >= 4 clk periods; cs setup/hold to the first/last sck edge SHALL be >= 4 clk periods.

Reset
REQ-031 rst_n low SHALL asynchronously force: FSM IDLE, miso 0, tx_ready 1, rx_valid 0, rx_data 0, rx_overrun 0, bit counter 0, shift/holding/synchroniser registers 0 (synchroniser cs flops to 1).
REQ-032 Reset during SHIFT SHALL abort the word; after release the block waits for a fresh cs falling edge.

Configuration
REQ-033 Macro SPI_PERIPH_OVERRUN_EN defined: a word completing while rx_valid=1 and rx_ready=0 SHALL set rx_overrun (new word overwrites rx_data); ovr_clr=1 clears it next cycle, set taking priority.
REQ-034 Macro undefined: rx_overrun SHALL be constant 0, ovr_clr ignored, overwrite behaviour unchanged.

Verification
REQ-035 WIDTH=8, mode 0, tx 0xA5 preloaded, master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C, rx_valid=1.
REQ-036 Mode 3 (CPOL=1,CPHA=1), WIDTH=16, tx 0x8001, mosi 0xBEEF -> miso 0x8001 MSB-first, rx_data=0xBEEF.
REQ-037 Two words under one cs, tx 0x11 then 0x22 written before word 1 ends -> miso 0x11,0x22; rx_valid pulses twice; tx_ready high after each load.
REQ-038 No tx write, cs low 8 sck -> miso all 0, rx still received.
REQ-039 cs raised after 5 sck of word -> no rx_valid; next transfer of 0x5A returns rx_data=0x5A.
REQ-040 SPI_PERIPH_OVERRUN_EN, rx_ready=0, two words 0x01,0x02 -> rx_data=0x02, rx_overrun=1; ovr_clr pulse -> rx_overrun=0; without macro rx_overrun stays 0.

Source files
------------

// File: rtl/spi_peripheral_if.sv
// Bus bundle between an SPI peripheral and its system-side user: the serial pins plus the
// transmit/receive word handshakes. The slave modport is the peripheral's view.
interface spi_peripheral_if #(
    parameter int WIDTH = 8
);
    logic             cs;
    logic             sck;
    logic             mosi;
    logic             miso;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             ovr_clr;
    logic             rx_overrun;

    modport slave (
        input  cs, sck, mosi, tx_data, tx_valid, rx_ready, ovr_clr,
        output miso, tx_ready, rx_data, rx_valid, rx_overrun
    );

    modport master (
        output cs, sck, mosi, tx_data, tx_valid, rx_ready, ovr_clr,
        input  miso, tx_ready, rx_data, rx_valid, rx_overrun
    );
endinterface

// File: rtl/spi_peripheral.sv
// SPI peripheral (all four CPOL/CPHA modes) oversampling cs/sck/mosi in the clk domain.
// Define SPI_PERIPH_OVERRUN_EN to enable the sticky rx_overrun flag.
module spi_peripheral #(
    parameter int WIDTH = 8,
    parameter bit CPOL  = 1'b0,
    parameter bit CPHA  = 1'b0
) (
    input logic           clk,
    input logic           rst_n,
    spi_peripheral_if.slave bus
);
    localparam int                 CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [2:0]         cs_sync_q, cs_sync_d;
    logic [2:0]         sck_sync_q, sck_sync_d;
    logic [1:0]         mosi_sync_q, mosi_sync_d;
    logic [WIDTH-1:0]   tx_sh_q, tx_sh_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [WIDTH-1:0]   rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0]   rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic lead_edge, trail_edge, sample_edge, shift_edge, cs_fall, cs_rise;
    logic active, start, load, word_done, tx_wr, miso_o;

    // Bit [1] of each chain is the synchronised level, bit [2] its previous value.
    always_comb begin
        cs_sync_d   = {cs_sync_q[1:0], bus.cs};
        sck_sync_d  = {sck_sync_q[1:0], bus.sck};
        mosi_sync_d = {mosi_sync_q[0], bus.mosi};
        lead_edge   = (sck_sync_q[1] != CPOL) && (sck_sync_q[2] == CPOL);
        trail_edge  = (sck_sync_q[1] == CPOL) && (sck_sync_q[2] != CPOL);
        sample_edge = CPHA ? trail_edge : lead_edge;
        shift_edge  = CPHA ? lead_edge : trail_edge;
        cs_fall     = !cs_sync_q[1] && cs_sync_q[2];
        cs_rise     = cs_sync_q[1] && !cs_sync_q[2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = SHIFT;
            SHIFT:   if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A cs rise masks any sck edge seen in the same cycle.
    always_comb begin
        active = 1'b0;
        start  = 1'b0;
        miso_o = 1'b0;
        case (state_q)
            IDLE:  start = cs_fall;
            SHIFT: begin
                active = !cs_rise;
                miso_o = tx_sh_q[WIDTH-1];
            end
            default: ;
        endcase
    end

    always_comb begin
        tx_sh_d     = tx_sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        cnt_d       = cnt_q;
        word_done   = 1'b0;
        load        = start;
        tx_wr       = bus.tx_valid && !hold_full_q;

        if ((state_q == SHIFT) && cs_rise) cnt_d = '0;

        if (active && sample_edge) begin
            rx_sh_d = {rx_sh_q[WIDTH-2:0], mosi_sync_q[1]};
            if (cnt_q == LAST) begin
                cnt_d     = '0;
                word_done = 1'b1;
                load      = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // The shift edge at bit count 0 is the one bordering a word start, where the
        // freshly loaded MSB must stay on miso.
        if (active && shift_edge && (cnt_q != '0)) tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};

        if (tx_wr) begin
            hold_d      = bus.tx_data;
            hold_full_d = 1'b1;
        end

        if (load) begin
            if (hold_full_q) begin
                tx_sh_d     = hold_q;
                hold_full_d = 1'b0;
            end else if (tx_wr) begin
                tx_sh_d     = bus.tx_data;
                hold_full_d = 1'b0;
            end else begin
                tx_sh_d = '0;
            end
        end

        if (rx_valid_q && bus.rx_ready) rx_valid_d = 1'b0;
        if (word_done) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_sh_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q   <= 3'b111;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            tx_sh_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            tx_sh_q     <= tx_sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef SPI_PERIPH_OVERRUN_EN
    logic rx_overrun_q, rx_overrun_d;

    always_comb begin
        rx_overrun_d = rx_overrun_q;
        if (bus.ovr_clr) rx_overrun_d = 1'b0;
        if (word_done && rx_valid_q && !bus.rx_ready) rx_overrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_overrun_q <= 1'b0;
        end else begin
            rx_overrun_q <= rx_overrun_d;
        end
    end

    assign bus.rx_overrun = rx_overrun_q;
`else
    assign bus.rx_overrun = 1'b0;
`endif

    assign bus.miso     = miso_o;
    assign bus.tx_ready = !hold_full_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench: a mode-0 8-bit instance and a mode-3 16-bit instance driven by a bit-banged master.
module tb_spi_peripheral;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_peripheral_if #(.WIDTH(8))  bus0 ();
    spi_peripheral_if #(.WIDTH(16)) bus3 ();

    spi_peripheral #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    spi_peripheral #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b1)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

`ifdef SPI_PERIPH_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr0(input logic [7:0] d);
        bus0.tx_data  = d;
        bus0.tx_valid = 1'b1;
        tick(1);
        bus0.tx_valid = 1'b0;
    endtask

    task automatic consume0();
        bus0.rx_ready = 1'b1;
        tick(1);
        bus0.rx_ready = 1'b0;
    endtask

    // Mode 0 master: drive mosi while sck is low, capture miso just before the rising edge.
    task automatic xfer0(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        logic [7:0] sh;
        sh = mo;
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            bus0.mosi = sh[7];
            sh = {sh[6:0], 1'b0};
            tick(8);
            mi = {mi[6:0], bus0.miso};
            bus0.sck = 1'b1;
            tick(8);
            bus0.sck = 1'b0;
        end
        tick(8);
    endtask

    logic [7:0]  mi;
    logic [15:0] mi3;
    logic [15:0] sh3;

    initial begin
        rst_n = 1'b0;
        bus0.cs = 1'b1; bus0.sck = 1'b0; bus0.mosi = 1'b0;
        bus0.tx_data = '0; bus0.tx_valid = 1'b0; bus0.rx_ready = 1'b0; bus0.ovr_clr = 1'b0;
        bus3.cs = 1'b1; bus3.sck = 1'b1; bus3.mosi = 1'b0;
        bus3.tx_data = '0; bus3.tx_valid = 1'b0; bus3.rx_ready = 1'b0; bus3.ovr_clr = 1'b0;
        tick(3);
        check("rst_miso",     32'(bus0.miso), 32'h0);
        check("rst_tx_ready", 32'(bus0.tx_ready), 32'h1);
        check("rst_rx_valid", 32'(bus0.rx_valid), 32'h0);
        check("rst_rx_data",  32'(bus0.rx_data), 32'h0);
        check("rst_overrun",  32'(bus0.rx_overrun), 32'h0);
        check("rst3_tx_ready", 32'(bus3.tx_ready), 32'h1);
        check("rst3_miso",     32'(bus3.miso), 32'h0);
        rst_n = 1'b1;
        tick(5);

        // Mode 0 single word, 0xA5 preloaded, master sends 0x3C
        wr0(8'hA5);
        check("a5_tx_ready_full", 32'(bus0.tx_ready), 32'h0);
        bus0.cs = 1'b0;
        tick(8);
        check("a5_tx_ready_loaded", 32'(bus0.tx_ready), 32'h1);
        xfer0(8'h3C, 8, mi);
        check("a5_miso_word", 32'(mi), 32'hA5);
        bus0.cs = 1'b1;
        tick(8);
        check("a5_rx_data",  32'(bus0.rx_data), 32'h3C);
        check("a5_rx_valid", 32'(bus0.rx_valid), 32'h1);
        check("a5_idle_miso", 32'(bus0.miso), 32'h0);
        consume0();
        check("a5_rx_consumed", 32'(bus0.rx_valid), 32'h0);

        // Two back-to-back words under one cs
        wr0(8'h11);
        bus0.cs = 1'b0;
        tick(8);
        check("b2b_ready_after_load1", 32'(bus0.tx_ready), 32'h1);
        wr0(8'h22);
        check("b2b_ready_held", 32'(bus0.tx_ready), 32'h0);
        xfer0(8'hA1, 8, mi);
        check("b2b_miso_w1", 32'(mi), 32'h11);
        check("b2b_ready_after_load2", 32'(bus0.tx_ready), 32'h1);
        check("b2b_rx_valid_w1", 32'(bus0.rx_valid), 32'h1);
        check("b2b_rx_data_w1",  32'(bus0.rx_data), 32'hA1);
        consume0();
        check("b2b_rx_consumed_w1", 32'(bus0.rx_valid), 32'h0);
        xfer0(8'hB2, 8, mi);
        check("b2b_miso_w2", 32'(mi), 32'h22);
        check("b2b_rx_valid_w2", 32'(bus0.rx_valid), 32'h1);
        check("b2b_rx_data_w2",  32'(bus0.rx_data), 32'hB2);
        bus0.cs = 1'b1;
        tick(8);
        consume0();

        // Underrun: nothing written, zeros go out, receive still works
        bus0.cs = 1'b0;
        tick(8);
        xfer0(8'h96, 8, mi);
        check("udr_miso", 32'(mi), 32'h00);
        bus0.cs = 1'b1;
        tick(8);
        check("udr_rx_data",  32'(bus0.rx_data), 32'h96);
        check("udr_rx_valid", 32'(bus0.rx_valid), 32'h1);
        consume0();

        // Abort after 5 bits: partial discarded, holding register kept
        bus0.cs = 1'b0;
        tick(8);
        wr0(8'h69);
        xfer0(8'hFF, 5, mi);
        bus0.cs = 1'b1;
        tick(8);
        check("abort_no_rx_valid", 32'(bus0.rx_valid), 32'h0);
        check("abort_hold_kept",   32'(bus0.tx_ready), 32'h0);
        bus0.cs = 1'b0;
        tick(8);
        check("abort_hold_loaded", 32'(bus0.tx_ready), 32'h1);
        xfer0(8'h5A, 8, mi);
        check("abort_next_miso", 32'(mi), 32'h69);
        bus0.cs = 1'b1;
        tick(8);
        check("abort_next_rx_data",  32'(bus0.rx_data), 32'h5A);
        check("abort_next_rx_valid", 32'(bus0.rx_valid), 32'h1);
        consume0();

        // Overrun: two words, nobody consumes
        bus0.cs = 1'b0;
        tick(8);
        xfer0(8'h01, 8, mi);
        check("ovr_rx_valid_w1", 32'(bus0.rx_valid), 32'h1);
        check("ovr_flag_w1",     32'(bus0.rx_overrun), 32'h0);
        xfer0(8'h02, 8, mi);
        bus0.cs = 1'b1;
        tick(8);
        check("ovr_rx_data", 32'(bus0.rx_data), 32'h02);
        check("ovr_flag",    32'(bus0.rx_overrun), 32'(OVR_EXP));
        check("ovr_rx_valid", 32'(bus0.rx_valid), 32'h1);
        bus0.ovr_clr = 1'b1;
        tick(1);
        bus0.ovr_clr = 1'b0;
        check("ovr_cleared", 32'(bus0.rx_overrun), 32'h0);
        consume0();

        // Reset in the middle of a word, then a fresh transfer
        bus0.cs = 1'b0;
        tick(8);
        wr0(8'hF0);
        xfer0(8'hE7, 3, mi);
        rst_n = 1'b0;
        #1;
        check("midrst_miso",     32'(bus0.miso), 32'h0);
        check("midrst_tx_ready", 32'(bus0.tx_ready), 32'h1);
        check("midrst_rx_data",  32'(bus0.rx_data), 32'h0);
        bus0.cs = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check("midrst_idle_miso", 32'(bus0.miso), 32'h0);
        wr0(8'hC3);
        bus0.cs = 1'b0;
        tick(8);
        xfer0(8'h3A, 8, mi);
        check("midrst_next_miso", 32'(mi), 32'hC3);
        bus0.cs = 1'b1;
        tick(8);
        check("midrst_next_rx_data", 32'(bus0.rx_data), 32'h3A);
        consume0();

        // Mode 3, 16-bit: tx 0x8001, mosi 0xBEEF
        bus3.tx_data  = 16'h8001;
        bus3.tx_valid = 1'b1;
        tick(1);
        bus3.tx_valid = 1'b0;
        check("m3_tx_ready_full", 32'(bus3.tx_ready), 32'h0);
        bus3.cs = 1'b0;
        tick(8);
        sh3 = 16'hBEEF;
        mi3 = '0;
        for (int i = 0; i < 16; i++) begin
            bus3.sck  = 1'b0;
            bus3.mosi = sh3[15];
            sh3 = {sh3[14:0], 1'b0};
            tick(8);
            mi3 = {mi3[14:0], bus3.miso};
            bus3.sck = 1'b1;
            tick(8);
        end
        tick(8);
        bus3.cs = 1'b1;
        tick(8);
        check("m3_miso_word", 32'(mi3), 32'h8001);
        check("m3_rx_data",   32'(bus3.rx_data), 32'hBEEF);
        check("m3_rx_valid",  32'(bus3.rx_valid), 32'h1);
        check("m3_tx_ready",  32'(bus3.tx_ready), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
